// File: rtl/modulo_updown_counter_if.sv
// Bundle for modulo_updown_counter: controls in, count and status out.
// master drives en/dir/load/load_val/max_val/sat; slave returns cnt/tc/wrap_p/sat_flag.
interface modulo_updown_counter_if #(
  parameter int N = 10
) ();
  logic         en;
  logic         dir;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] max_val;
  logic         sat;
  logic [N-1:0] cnt;
  logic         tc;
  logic         wrap_p;
  logic         sat_flag;

  modport master (
    output en, dir, load, load_val, max_val, sat,
    input  cnt, tc, wrap_p, sat_flag
  );

  modport slave (
    input  en, dir, load, load_val, max_val, sat,
    output cnt, tc, wrap_p, sat_flag
  );
endinterface

// File: rtl/modulo_updown_counter.sv
// Up/down counter with runtime modulus, sync load, wrap or saturate mode.
// Ports: clk, rst (sync, active-high), bus (slave side of modulo_updown_counter_if).
module modulo_updown_counter #(
  parameter int           N       = 10,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input logic clk,
  input logic rst,
  modulo_updown_counter_if.slave bus
);

  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [N-1:0] ZERO = '0;

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         sat_q;
  logic         sat_d;

  logic over;
  logic top;
  logic bot;
  logic [N-1:0] clamp;

  // over: max_val was lowered below the current count
  assign over  = cnt_q > bus.max_val;
  assign top   = cnt_q == bus.max_val;
  assign bot   = cnt_q == ZERO;
  assign clamp = (bus.load_val > bus.max_val)
               ? bus.max_val : bus.load_val;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (bus.load) begin
      cnt_d = clamp;
      sat_d = 1'b0;
    end else if (bus.en) begin
      unique case (1'b1)
        over & bus.dir & ~bus.sat: begin
          cnt_d  = ZERO;
          wrap_d = 1'b1;
        end
        over & ~(bus.dir & ~bus.sat): begin
          cnt_d = bus.max_val;
        end
        ~over & bus.dir & ~top: begin
          cnt_d = cnt_q + ONE;
        end
        ~over & bus.dir & top & bus.sat: begin
          sat_d = 1'b1;
        end
        ~over & bus.dir & top & ~bus.sat: begin
          cnt_d  = ZERO;
          wrap_d = 1'b1;
        end
        ~over & ~bus.dir & ~bot: begin
          cnt_d = cnt_q - ONE;
        end
        ~over & ~bus.dir & bot & bus.sat: begin
          sat_d = 1'b1;
        end
        ~over & ~bus.dir & bot & ~bus.sat: begin
          cnt_d  = bus.max_val;
          wrap_d = 1'b1;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_VAL;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  // tc is deliberately not gated by load
  assign bus.tc = bus.en &
    (bus.dir ? (cnt_q >= bus.max_val)
             : bot);

  assign bus.cnt      = cnt_q;
  assign bus.wrap_p   = wrap_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Bench for modulo_updown_counter, N=4, RST_VAL=3.
// Scenario tables push expected outputs to a queue, popped after each edge.
module tb_modulo_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  modulo_updown_counter_if #(.N(4)) bus ();

  modulo_updown_counter #(
    .N(4),
    .RST_VAL(4'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit r;
    bit l;
    int lv;
    bit e;
    bit d;
    int m;
    bit s;
    bit tc;
    int c;
    bit w;
    bit f;
  } step_t;

  typedef struct {
    logic [3:0] cnt;
    logic       wrap;
    logic       satf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic apply(input step_t s);
    @(negedge clk);
    rst          = s.r;
    bus.load     = s.l;
    bus.load_val = 4'(s.lv);
    bus.en       = s.e;
    bus.dir      = s.d;
    bus.max_val  = 4'(s.m);
    bus.sat      = s.s;
    sb.push_back('{cnt: 4'(s.c), wrap: s.w, satf: s.f});
  endtask

  task automatic test_reset();
    step_t t[9];
    exp_t  e;
    t[0] = '{1,0,0,0,1,9,0, 0, 3,0,0};
    t[1] = '{0,0,0,1,1,9,0, 0, 4,0,0};
    t[2] = '{0,0,0,1,1,9,0, 0, 5,0,0};
    t[3] = '{0,0,0,1,1,9,0, 0, 6,0,0};
    t[4] = '{0,0,0,1,1,9,0, 0, 7,0,0};
    t[5] = '{0,0,0,1,1,9,0, 0, 8,0,0};
    t[6] = '{0,0,0,1,1,9,0, 0, 9,0,0};
    t[7] = '{0,0,0,1,1,9,0, 1, 0,1,0};
    t[8] = '{0,0,0,1,1,9,0, 0, 1,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL reset_count tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL reset_count out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_down_wrap();
    step_t t[3];
    exp_t  e;
    t[0] = '{0,0,0,1,0,9,0, 0, 0,0,0};
    t[1] = '{0,0,0,1,0,9,0, 1, 9,1,0};
    t[2] = '{0,0,0,1,0,9,0, 0, 8,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL down_wrap tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL down_wrap out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_saturate();
    step_t t[5];
    exp_t  e;
    t[0] = '{0,1,4,0,1,5,1, 0, 4,0,0};
    t[1] = '{0,0,0,1,1,5,1, 0, 5,0,0};
    t[2] = '{0,0,0,1,1,5,1, 1, 5,0,1};
    t[3] = '{0,0,0,1,1,5,1, 1, 5,0,1};
    // load with en high: tc still reflects cnt=max, load wins
    t[4] = '{0,1,2,1,1,5,1, 1, 2,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL saturate tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL saturate out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_load_clamp();
    step_t t[3];
    exp_t  e;
    t[0] = '{0,1,12,1,1,7,0, 0, 7,0,0};
    t[1] = '{1,1,5,1,1,7,0, 1, 3,0,0};
    t[2] = '{0,1,6,0,0,7,0, 0, 6,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL load_clamp tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL load_clamp out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_shrink();
    step_t t[7];
    exp_t  e;
    t[0] = '{0,1,8,0,1,9,0, 0, 8,0,0};
    t[1] = '{0,0,0,0,1,5,0, 0, 8,0,0};
    t[2] = '{0,0,0,1,1,5,0, 1, 0,1,0};
    t[3] = '{0,1,8,0,0,9,0, 0, 8,0,0};
    t[4] = '{0,0,0,1,0,5,0, 0, 5,0,0};
    t[5] = '{0,1,8,0,1,9,1, 0, 8,0,0};
    t[6] = '{0,0,0,1,1,5,1, 1, 5,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL shrink tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL shrink out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_degenerate();
    step_t t[7];
    exp_t  e;
    t[0] = '{0,1,3,0,1,0,0, 0, 0,0,0};
    t[1] = '{0,0,0,1,1,0,0, 1, 0,1,0};
    t[2] = '{0,0,0,1,1,0,0, 1, 0,1,0};
    t[3] = '{0,0,0,1,1,0,0, 1, 0,1,0};
    t[4] = '{0,0,0,1,0,0,1, 1, 0,0,1};
    t[5] = '{0,0,0,0,0,0,1, 0, 0,0,1};
    t[6] = '{0,0,0,1,1,0,1, 1, 0,0,1};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL degenerate tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL degenerate out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t t[5];
    exp_t  e;
    t[0] = '{0,1,7,0,1,9,1, 0, 7,0,0};
    t[1] = '{0,0,0,1,1,9,1, 0, 8,0,0};
    t[2] = '{1,0,0,1,1,9,1, 0, 3,0,0};
    t[3] = '{0,0,0,1,1,9,1, 0, 4,0,0};
    t[4] = '{0,0,0,1,0,9,1, 0, 3,0,0};
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_vec++;
      if (bus.tc !== t[i].tc) begin
        n_err++;
        $display("FAIL back_to_back tc step %0d: got %b want %b",
                 i, bus.tc, t[i].tc);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if ({bus.cnt, bus.wrap_p, bus.sat_flag} !== {e.cnt, e.wrap, e.satf}) begin
        n_err++;
        $display("FAIL back_to_back out step %0d: got cnt=%0d w=%b f=%b want cnt=%0d w=%b f=%b",
                 i, bus.cnt, bus.wrap_p, bus.sat_flag, e.cnt, e.wrap, e.satf);
      end
    end
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.dir      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.max_val  = '0;
    bus.sat      = 1'b0;
    test_reset();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_shrink();
    test_degenerate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modulo_updown_counter.md
# modulo_updown_counter

Parametrised N-bit up/down counter with a runtime modulus, synchronous load, selectable wrap or saturate behaviour, a terminal-count output and wrap/saturation status. It generalises the datapath's basic load/enable up/down counter, which has no reset, fixed 2^N roll-over and no mode control. It sits in the same datapath as a drop-in timing/sequence counter. All state updates occur on the rising edge of `clk`.

## Interface

**Parameters**
- `N`, default 10: counter width in bits; legal for N ≥ 2.
- `RST_VAL`, default 0: value of `cnt` after reset; must be ≤ the `max_val` in use at reset release.

**Ports**
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: count enable; one step per cycle while high.
- `dir` in 1: count direction; 1 = up, 0 = down.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in N: value to load.
- `max_val` in N: modulus minus 1; the legal count range is 0..`max_val`.
- `sat` in 1: mode select; 0 = wrap, 1 = saturate.
- `cnt` out N: registered count.
- `tc` out 1: combinational terminal count.
- `wrap_p` out 1: registered one-cycle pulse, high after a wrap.
- `sat_flag` out 1: registered, sticky; high after a step blocked by saturation.

## Operation

**Priority per edge:** `rst` > `load` > `en`. With none of these asserted, all registers hold, except that `wrap_p` returns to 0.

**Reset.** `rst`=1 sets `cnt`=`RST_VAL`, `wrap_p`=0, `sat_flag`=0.

**Load.** `load`=1 sets `cnt`=min(`load_val`, `max_val`), `wrap_p`=0, `sat_flag`=0. `en` and `dir` are ignored in a load cycle.

**Count (`en`=1, `cnt` ≤ `max_val`):**
- Up, `cnt` < `max_val`: `cnt`+1.
- Up, `cnt` = `max_val`, wrap mode: `cnt`=0 and `wrap_p`=1.
- Up, `cnt` = `max_val`, saturate mode: `cnt` holds and `sat_flag`=1.
- Down, `cnt` > 0: `cnt`−1.
- Down, `cnt` = 0, wrap mode: `cnt`=`max_val` and `wrap_p`=1.
- Down, `cnt` = 0, saturate mode: `cnt` holds and `sat_flag`=1.

**Out-of-range (`max_val` lowered below `cnt` at runtime, `en`=1):**
- Up in wrap mode: `cnt`=0 and `wrap_p`=1.
- All other cases: `cnt`=`max_val`; no pulse, no `sat_flag`.
- With `en`=0 the out-of-range `cnt` holds unchanged.

**`max_val`=0:**
- Wrap mode: `cnt` stays 0 and `wrap_p` pulses on every enabled cycle.
- Saturate mode: `sat_flag` sets on the first enabled cycle.

**`tc` (combinational):** `tc` = `en` & (`dir` ? (`cnt` ≥ `max_val`) : (`cnt` == 0)). It is high when the next enabled step would wrap or saturate, and is not gated by `load`.

**Arithmetic:** comparisons are unsigned N-bit. There is no 2^N roll-over path; all roll-over goes through `max_val`.

## Timing

- Latency is 1 cycle from `en`/`load`/`rst` to `cnt`; `wrap_p` and `sat_flag` update on the same edge as `cnt`.
- `tc` has zero latency; it follows `cnt`, `en`, `dir` and `max_val` combinationally.
- `wrap_p` is high for exactly one cycle per wrap. Consecutive wraps (`max_val`=0) hold it high continuously.
- `sat_flag` stays high until `rst` or `load`. A saturated hold does not clear it.
- `dir`, `sat` and `max_val` are sampled every cycle; a change takes effect on the next edge with no pipeline delay.
- Reset asserted mid-count overrides everything on that edge. The first count occurs on the edge after `rst` deasserts.

## Test plan

- **Reset and basic count.** N=4, `RST_VAL`=3, `max_val`=9, wrap mode. Assert `rst` one cycle, then `en`=1, `dir`=1 for 8 cycles. Required: `cnt` = 3,4,…,9,0,1; `wrap_p` high only in the cycle `cnt`=0; `tc`=1 while `cnt`=9.
- **Down wrap.** From `cnt`=1, `max_val`=9, `dir`=0, `en`=1 for 3 cycles. Required: `cnt` = 0, 9, 8; `wrap_p` pulses with `cnt`=9; `tc`=1 while `cnt`=0.
- **Saturate.** `sat`=1, `max_val`=5, load 4, `dir`=1, `en`=1 for 3 cycles. Required: `cnt` = 5,5,5; `sat_flag` rises on the second edge and stays high. Then `load`=1, `load_val`=2: `cnt`=2 and `sat_flag`=0.
- **Load clamp and priority.** `max_val`=7; `load`=1 and `en`=1 with `load_val`=12. Required: `cnt`=7 (load wins, value clamped). Then `rst`=1 and `load`=1 together: `cnt`=`RST_VAL`.
- **Runtime modulus shrink.** `cnt`=8, set `max_val`=5. With `en`=0: `cnt` holds 8 and `tc`=0. Then `en`=1, `dir`=1, wrap mode: `cnt`=0 with a `wrap_p` pulse. Repeat from 8 with `dir`=0: `cnt`=5 and no pulse.
- **Degenerate modulus.** `max_val`=0, wrap mode, `en`=1, `dir`=1 for 3 cycles. Required: `cnt`=0 throughout and `wrap_p` high for all 3 cycles. In saturate mode, `sat_flag` sets after the first edge.
